// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   State and advance-kind enums, default widths, opcode constants and
//   opcode field position.
package fetch_pkg;

  localparam int unsigned AddrWidth  = 10;
  localparam int unsigned InstrWidth = 18;
  localparam int unsigned OpcWidth   = 4;

  // Opcode occupies the top OpcWidth bits of the instruction.
  localparam int unsigned OpcMsb = InstrWidth - 1;
  localparam int unsigned OpcLsb = InstrWidth - OpcWidth;

  localparam logic [OpcWidth-1:0] JmpOpc  = 4'hE;
  localparam logic [OpcWidth-1:0] HaltOpc = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StHold,
    StAdv,
    StHalt
  } fetch_state_e;

  typedef enum logic {
    AdvSeq,
    AdvJump
  } adv_kind_e;

endpackage

// File: rtl/fetch_opc_decode.sv
// Combinational opcode decoder for fetched instruction words.
//   instr   : raw instruction from memory
//   is_jmp  : opcode is the unconditional relative jump
//   is_halt : opcode is halt
//   offset  : low ADDR_W bits, the jump offset field
module fetch_opc_decode
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = AddrWidth,
  parameter int unsigned         INSTR_W  = InstrWidth,
  parameter int unsigned         OPC_W    = OpcWidth,
  parameter logic [OPC_W-1:0]    JMP_OPC  = JmpOpc,
  parameter logic [OPC_W-1:0]    HALT_OPC = HaltOpc
) (
  input  logic [INSTR_W-1:0] instr,
  output logic               is_jmp,
  output logic               is_halt,
  output logic [ADDR_W-1:0]  offset
);

  logic [OPC_W-1:0] opc;
  logic             unused_mid;

  assign opc     = instr[INSTR_W-1 -: OPC_W];
  assign is_jmp  = (opc == JMP_OPC);
  assign is_halt = (opc == HALT_OPC);
  assign offset  = instr[ADDR_W-1:0];

  // Bits between the offset field and the opcode carry no meaning here.
  assign unused_mid = ^instr[INSTR_W-OPC_W-1:ADDR_W];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage between the PC and decode/execute.
//   clk, rst          : clock, asynchronous active-high reset
//   pc_addr           : current PC
//   pc_enable/pc_next : sequential +1 advance request
//   pc_is_jump        : add pc_offset to the PC
//   pc_offset         : two's-complement PC offset
//   imem_req/addr     : instruction memory read request
//   imem_ack/rdata    : read data valid / data
//   ir_valid/ir       : instruction offered to the consumer
//   ir_ready          : consumer accepts ir
//   redirect_valid    : taken branch from execute (pulse), with redirect_offset
//   halted            : HALT fetched, sticky until rst
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = AddrWidth,
  parameter int unsigned         INSTR_W  = InstrWidth,
  parameter int unsigned         OPC_W    = OpcWidth,
  parameter logic [OPC_W-1:0]    JMP_OPC  = JmpOpc,
  parameter logic [OPC_W-1:0]    HALT_OPC = HaltOpc
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_enable,
  output logic               pc_next,
  output logic               pc_is_jump,
  output logic [ADDR_W-1:0]  pc_offset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir,
  input  logic               ir_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_offset,
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  adv_kind_e          adv_kind_q, adv_kind_d;
  logic [ADDR_W-1:0]  adv_off_q, adv_off_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_off_q, pend_off_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;

  logic              dec_is_jmp;
  logic              dec_is_halt;
  logic [ADDR_W-1:0] dec_offset;

  fetch_opc_decode #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .OPC_W    (OPC_W),
    .JMP_OPC  (JMP_OPC),
    .HALT_OPC (HALT_OPC)
  ) u_decode (
    .instr   (imem_rdata),
    .is_jmp  (dec_is_jmp),
    .is_halt (dec_is_halt),
    .offset  (dec_offset)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      adv_kind_q <= AdvSeq;
      adv_off_q  <= '0;
      pend_q     <= 1'b0;
      pend_off_q <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adv_kind_q <= adv_kind_d;
      adv_off_q  <= adv_off_d;
      pend_q     <= pend_d;
      pend_off_q <= pend_off_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adv_kind_d = adv_kind_q;
    adv_off_d  = adv_off_q;
    pend_d     = pend_q;
    pend_off_d = pend_off_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;

    unique case (state_q)
      StIdle: state_d = StReq;

      StReq: begin
        if (imem_ack) begin
          if (pend_q || redirect_valid) begin
            // A same-cycle redirect is newer than any stored one.
            adv_kind_d = AdvJump;
            adv_off_d  = redirect_valid ? redirect_offset : pend_off_q;
            pend_d     = 1'b0;
            state_d    = StAdv;
          end else if (dec_is_jmp) begin
            adv_kind_d = AdvJump;
            adv_off_d  = dec_offset;
            state_d    = StAdv;
          end else if (dec_is_halt) begin
            state_d = StHalt;
          end else begin
            ir_d       = imem_rdata;
            ir_valid_d = 1'b1;
            state_d    = StHold;
          end
        end else if (redirect_valid) begin
          pend_d     = 1'b1;
          pend_off_d = redirect_offset;
        end
      end

      StHold: begin
        if (redirect_valid) begin
          ir_valid_d = 1'b0;
          adv_kind_d = AdvJump;
          adv_off_d  = redirect_offset;
          state_d    = StAdv;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
          adv_kind_d = AdvSeq;
          state_d    = StAdv;
        end
      end

      StAdv:  state_d = StReq;

      StHalt: state_d = StHalt;

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == StReq);
    imem_addr  = imem_req ? pc_addr : '0;
    pc_enable  = (state_q == StAdv) && (adv_kind_q == AdvSeq);
    pc_next    = pc_enable;
    pc_is_jump = (state_q == StAdv) && (adv_kind_q == AdvJump);
    pc_offset  = pc_is_jump ? adv_off_q : '0;
    halted     = (state_q == StHalt);
    ir_valid   = ir_valid_q;
    ir         = ir_q;
  end

endmodule
